// File: rtl/fsk4_tone_detector.sv
// rtl/fsk4_tone_detector.sv - non-coherent 4-FSK symbol detector (correlate, magnitude, argmax)
// Optional soft-decision outputs sym_mag/sym_margin under macro FSK4_DET_SOFT_EN.
module fsk4_tone_detector #(
    parameter int SPS   = 16,
    parameter int IN_W  = 18,
    parameter int LUT_W = 16,
    parameter int ACC_W = 20 + $clog2(SPS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [IN_W-1:0]  in_i,
    input  logic signed [IN_W-1:0]  in_q,
    input  logic                    in_valid,
    input  logic                    sym_align,
    output logic [1:0]              sym_out,
    output logic                    sym_valid,
    output logic                    locked
`ifdef FSK4_DET_SOFT_EN
    ,
    output logic [ACC_W-1:0]        sym_mag,
    output logic [ACC_W-1:0]        sym_margin
`endif
);

    localparam int PW = $clog2(SPS);
    localparam int PROD_W = IN_W + LUT_W;
    localparam logic [PW-1:0] INC [4] = '{PW'(SPS - 3), PW'(SPS - 1), PW'(1), PW'(3)};

    typedef enum logic {IDLE, RUN} state_t;

    function automatic logic signed [LUT_W-1:0] lut_val(input int k, input bit sine);
        real a, v;
        a = 2.0 * 3.14159265358979 * k / SPS;
        v = (sine ? $sin(a) : $cos(a)) * 32767.0;
        return (v >= 0.0) ? LUT_W'($rtoi(v + 0.5)) : LUT_W'(-$rtoi(0.5 - v));
    endfunction

    function automatic logic [ACC_W-1:0] sat_abs(input logic signed [ACC_W-1:0] x);
        if (x == {1'b1, {(ACC_W-1){1'b0}}})
            return {1'b0, {(ACC_W-1){1'b1}}};
        return x[ACC_W-1] ? ACC_W'(-x) : ACC_W'(x);
    endfunction

    logic signed [LUT_W-1:0] cos_lut [SPS];
    logic signed [LUT_W-1:0] sin_lut [SPS];

    for (genvar k = 0; k < SPS; k++) begin : g_lut
        assign cos_lut[k] = lut_val(k, 1'b0);
        assign sin_lut[k] = lut_val(k, 1'b1);
    end

    state_t state_q, state_d;
    logic [PW-1:0] n_q, n_eff;
    logic [PW-1:0] p_q [4];
    logic [PW-1:0] ph [4];
    logic signed [ACC_W-1:0] re_q [4], im_q [4], re_n [4], im_n [4], re_h [4], im_h [4];
    logic [ACC_W-1:0] mag_q [4];
    logic snap_v, s1_v, accept;
    logic [1:0] best_idx;
    logic [ACC_W-1:0] best_mag, second_mag;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        if (state_q == IDLE) begin
            if (in_valid && sym_align) begin
                state_d = RUN;
                accept  = 1'b1;
            end
        end else begin
            accept = in_valid;
        end
    end

    assign locked = (state_q == RUN);
    assign n_eff  = sym_align ? '0 : n_q;

    // Correlate against conj(tone): (I + jQ)(c - js); sym_align restarts from zero.
    always_comb begin
        logic signed [PROD_W-1:0] ic, qs, qc, is_p;
        for (int m = 0; m < 4; m++) begin
            ph[m]   = sym_align ? '0 : p_q[m];
            ic      = in_i * cos_lut[ph[m]];
            qs      = in_q * sin_lut[ph[m]];
            qc      = in_q * cos_lut[ph[m]];
            is_p    = in_i * sin_lut[ph[m]];
            re_n[m] = (sym_align ? '0 : re_q[m]) + ACC_W'(ic >>> 15) + ACC_W'(qs >>> 15);
            im_n[m] = (sym_align ? '0 : im_q[m]) + ACC_W'(qc >>> 15) - ACC_W'(is_p >>> 15);
        end
    end

    always_comb begin
        best_idx   = 2'd0;
        best_mag   = mag_q[0];
        second_mag = '0;
        for (int m = 1; m < 4; m++) begin
            if (mag_q[m] > best_mag) begin
                second_mag = best_mag;
                best_mag   = mag_q[m];
                best_idx   = 2'(m);
            end else if (mag_q[m] > second_mag) begin
                second_mag = mag_q[m];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n_q       <= '0;
            snap_v    <= 1'b0;
            s1_v      <= 1'b0;
            sym_out   <= 2'd0;
            sym_valid <= 1'b0;
            for (int m = 0; m < 4; m++) begin
                p_q[m]   <= '0;
                re_q[m]  <= '0;
                im_q[m]  <= '0;
                re_h[m]  <= '0;
                im_h[m]  <= '0;
                mag_q[m] <= '0;
            end
`ifdef FSK4_DET_SOFT_EN
            sym_mag    <= '0;
            sym_margin <= '0;
`endif
        end else begin
            snap_v    <= 1'b0;
            s1_v      <= snap_v;
            sym_valid <= s1_v;
            if (accept) begin
                n_q <= n_eff + 1'b1;
                for (int m = 0; m < 4; m++) begin
                    p_q[m] <= ph[m] + INC[m];
                    if (n_eff == PW'(SPS - 1)) begin
                        re_h[m] <= re_n[m];
                        im_h[m] <= im_n[m];
                        re_q[m] <= '0;
                        im_q[m] <= '0;
                    end else begin
                        re_q[m] <= re_n[m];
                        im_q[m] <= im_n[m];
                    end
                end
                if (n_eff == PW'(SPS - 1))
                    snap_v <= 1'b1;
            end
            // max + min/2 fits unsigned ACC_W because |x| < 2^(ACC_W-1)
            if (snap_v) begin
                for (int m = 0; m < 4; m++) begin
                    if (sat_abs(re_h[m]) >= sat_abs(im_h[m]))
                        mag_q[m] <= sat_abs(re_h[m]) + (sat_abs(im_h[m]) >> 1);
                    else
                        mag_q[m] <= sat_abs(im_h[m]) + (sat_abs(re_h[m]) >> 1);
                end
            end
            if (s1_v) begin
                sym_out <= best_idx;
`ifdef FSK4_DET_SOFT_EN
                sym_mag    <= best_mag;
                sym_margin <= best_mag - second_mag;
`endif
            end
        end
    end

endmodule

// File: tb/tb_fsk4_tone_detector.sv
// tb/tb_fsk4_tone_detector.sv - scoreboard bench for fsk4_tone_detector
module tb_fsk4_tone_detector;
    localparam int SPS   = 16;
    localparam int ACC_W = 24;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic signed [17:0] in_i = '0;
    logic signed [17:0] in_q = '0;
    logic in_valid = 1'b0;
    logic sym_align = 1'b0;
    logic [1:0] sym_out;
    logic sym_valid;
    logic locked;
`ifdef FSK4_DET_SOFT_EN
    logic [ACC_W-1:0] sym_mag, sym_margin;
`endif

    fsk4_tone_detector dut (
        .clk(clk), .rst(rst), .in_i(in_i), .in_q(in_q), .in_valid(in_valid),
        .sym_align(sym_align), .sym_out(sym_out), .sym_valid(sym_valid), .locked(locked)
`ifdef FSK4_DET_SOFT_EN
        , .sym_mag(sym_mag), .sym_margin(sym_margin)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0] esym;
        int         when;
    } exp_t;
    exp_t sbq[$];

    int total = 0;
    int passed = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total = total + 1;
        assert (obs === expv) passed = passed + 1;
        else begin
            fails = fails + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int tone_sample(input int f, input int n, input int amp, input bit quad);
        real a, v;
        a = 2.0 * 3.14159265358979 * f * n / SPS;
        v = amp * (quad ? $sin(a) : $cos(a));
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    endfunction

    function automatic logic [1:0] sym_of(input int f);
        case (f)
            -3:      return 2'b00;
            -1:      return 2'b01;
            1:       return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

    task automatic drive(input int f, input int n, input int amp, input bit al,
                         input bit push, input logic [1:0] esym);
        @(negedge clk);
        in_i      = 18'(tone_sample(f, n, amp, 1'b0));
        in_q      = 18'(tone_sample(f, n, amp, 1'b1));
        in_valid  = 1'b1;
        sym_align = al;
        if (push) sbq.push_back('{esym, cyc + 3});
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(negedge clk);
            in_valid  = 1'b0;
            sym_align = 1'b0;
        end
    endtask

    task automatic send_symbol(input int f, input int amp, input bit al, input bit gaps);
        for (int n = 0; n < SPS; n++) begin
            drive(f, n, amp, al && (n == 0), n == SPS - 1, (amp == 0) ? 2'b00 : sym_of(f));
            if (gaps && n < SPS - 1) idle(1);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sym_valid) begin
            if (sbq.size() == 0) begin
                check("unexpected_sym_valid", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                check("sym_out", 32'(sym_out), 32'(e.esym));
                check("sym_latency", 32'(cyc), 32'(e.when));
            end
        end
    end

    initial begin
        int diff;
        idle(3);
        check("reset_sym_out", 32'(sym_out), 32'd0);
        check("reset_sym_valid", 32'(sym_valid), 32'd0);
        check("reset_locked", 32'(locked), 32'd0);
        rst = 1'b0;

        for (int n = 0; n < 5; n++) drive(1, n, 20000, 1'b0, 1'b0, 2'b00);
        idle(1);
        check("idle_locked", 32'(locked), 32'd0);

        send_symbol(1, 20000, 1'b1, 1'b0);
        idle(4);
        check("run_locked", 32'(locked), 32'd1);
        check("sym_out_hold", 32'(sym_out), 32'd2);
`ifdef FSK4_DET_SOFT_EN
        diff = int'(sym_mag) - 20000 * SPS;
        check("sym_mag_near", 32'(diff >= -32 && diff <= 32), 32'd1);
`endif

        send_symbol(3, 20000, 1'b0, 1'b0);
        send_symbol(-1, 20000, 1'b0, 1'b0);
        send_symbol(-3, 20000, 1'b0, 1'b0);
        send_symbol(1, 20000, 1'b0, 1'b0);
        idle(4);

        send_symbol(1, 20000, 1'b0, 1'b1);
        idle(4);

        send_symbol(1, 0, 1'b0, 1'b0);
        idle(4);
`ifdef FSK4_DET_SOFT_EN
        check("zero_sym_mag", 32'(sym_mag), 32'd0);
        check("zero_sym_margin", 32'(sym_margin), 32'd0);
`endif

        for (int n = 0; n < 7; n++) drive(3, n, 20000, n == 0, 1'b0, 2'b00);
        send_symbol(-1, 20000, 1'b1, 1'b0);
        idle(4);

        for (int n = 0; n < 10; n++) drive(3, n, 20000, n == 0, 1'b0, 2'b00);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        check("rst_sym_out", 32'(sym_out), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_sym_valid", 32'(sym_valid), 32'd0);
        for (int n = 0; n < 20; n++) drive(1, n, 20000, 1'b0, 1'b0, 2'b00);
        idle(5);
        check("post_rst_locked", 32'(locked), 32'd0);

        check("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
